// File: rtl/threshold_pkg.sv
// Shared definitions for the threshold output path: pair layout, scheduler
// state encoding and a small width helper.
package threshold_pkg;

  localparam int PIX_W  = 8;
  localparam int PAIR_W = 6 * PIX_W;

  // Field offsets inside a packed pair {R_even, G_even, B_even, R_odd, G_odd, B_odd}.
  localparam int R_EVEN_LSB = 5 * PIX_W;
  localparam int G_EVEN_LSB = 4 * PIX_W;
  localparam int B_EVEN_LSB = 3 * PIX_W;
  localparam int R_ODD_LSB  = 2 * PIX_W;
  localparam int G_ODD_LSB  = 1 * PIX_W;
  localparam int B_ODD_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_pair_fifo.sv
// Small synchronous FIFO for pixel pairs. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module pixel_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Read data is presented combinationally from the head entry.
  assign pop_data = mem[rd_ptr[ADDR_W-1:0]];

  // Pointer update; reset and flush both return the FIFO to empty.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/frame_write_scheduler.sv
// Frame write scheduler: buffers incoming pixel pairs and re-issues them in
// raster order toward the BMP writer, with a blanking gap after every row and
// a one-cycle frame_done pulse once the final pair has been presented.
module frame_write_scheduler
  import threshold_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int BLANK_CYCLES = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PAIR_W-1:0]                    in_pair,
  output logic                                 horizontal_Pulse,
  output logic [PIX_W-1:0]                     data_Red_Even,
  output logic [PIX_W-1:0]                     data_Green_Even,
  output logic [PIX_W-1:0]                     data_Blue_Even,
  output logic [PIX_W-1:0]                     data_Red_Odd,
  output logic [PIX_W-1:0]                     data_Green_Odd,
  output logic [PIX_W-1:0]                     data_Blue_Odd,
  output logic [width_of(IMAGE_HEIGHT)-1:0]    row,
  output logic [width_of(IMAGE_WIDTH/2)-1:0]   col,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam int ROW_W = width_of(IMAGE_HEIGHT);
  localparam int COL_W = width_of(IMAGE_WIDTH / 2);
  localparam int BLK_W = width_of(BLANK_CYCLES + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH / 2 - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  sched_state_e      state;
  sched_state_e      next_state;

  // Position of the next pair to be popped (the outputs row/col describe the
  // pair already on the data bus).
  logic [ROW_W-1:0]  cnt_row;
  logic [COL_W-1:0]  cnt_col;
  logic [BLK_W-1:0]  blank_cnt;

  logic [PAIR_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;

  logic              start_ok;
  logic              pop;
  logic              last_col;
  logic              last_row;
  logic              busy_next;
  logic              frame_done_next;

  // Acceptance depends only on the registered busy flag and fullness, so a
  // full FIFO never accepts in the same cycle it pops.
  assign in_ready = busy && !fifo_full;
  assign push     = in_valid && in_ready;

  assign last_col = (cnt_col == COL_LAST);
  assign last_row = (cnt_row == ROW_LAST);

  pixel_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (start_ok),
    .push      (push),
    .push_data (in_pair),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode: row ends go to BLANK (unless no gap is configured),
  // the final pair of the frame goes to DONE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = ACTIVE;
      end
      ACTIVE: begin
        if (pop && last_col) begin
          if (last_row)               next_state = DONE;
          else if (BLANK_CYCLES == 0) next_state = ACTIVE;
          else                        next_state = BLANK;
        end
      end
      BLANK: begin
        if (blank_cnt == BLK_LAST) next_state = ACTIVE;
      end
      DONE: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode: pop strobe, start qualification and next values of the
  // registered status flags.
  always_comb begin
    start_ok        = (state == IDLE) && start;
    pop             = (state == ACTIVE) && !fifo_empty;
    busy_next       = start_ok || (state != IDLE);
    frame_done_next = (state == DONE);
  end

  // Raster position of the next pair; cleared by reset and by an accepted start.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      cnt_row <= '0;
      cnt_col <= '0;
    end else if (pop) begin
      if (last_col) begin
        cnt_col <= '0;
        cnt_row <= last_row ? '0 : cnt_row + 1'b1;
      end else begin
        cnt_col <= cnt_col + 1'b1;
      end
    end
  end

  // Blanking gap length counter, running only while in BLANK.
  always_ff @(posedge clk) begin
    if (reset || (state != BLANK)) blank_cnt <= '0;
    else                           blank_cnt <= blank_cnt + 1'b1;
  end

  // Output registers: the popped pair and its position appear together one
  // cycle after the pop; data and position hold when nothing is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      horizontal_Pulse <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      row              <= '0;
      col              <= '0;
      data_Red_Even    <= '0;
      data_Green_Even  <= '0;
      data_Blue_Even   <= '0;
      data_Red_Odd     <= '0;
      data_Green_Odd   <= '0;
      data_Blue_Odd    <= '0;
    end else begin
      horizontal_Pulse <= pop;
      busy             <= busy_next;
      frame_done       <= frame_done_next;
      if (pop) begin
        row             <= cnt_row;
        col             <= cnt_col;
        data_Red_Even   <= fifo_data[R_EVEN_LSB +: PIX_W];
        data_Green_Even <= fifo_data[G_EVEN_LSB +: PIX_W];
        data_Blue_Even  <= fifo_data[B_EVEN_LSB +: PIX_W];
        data_Red_Odd    <= fifo_data[R_ODD_LSB  +: PIX_W];
        data_Green_Odd  <= fifo_data[G_ODD_LSB  +: PIX_W];
        data_Blue_Odd   <= fifo_data[B_ODD_LSB  +: PIX_W];
      end
    end
  end

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed bench for frame_write_scheduler with an 8x4 frame: one instance
// with a 2-cycle row gap, one with no gap.
module tb_frame_write_scheduler;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int NPAIR = (W / 2) * H;

  typedef struct {
    int          cyc;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [47:0] data;
  } pulse_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance with BLANK_CYCLES = 2
  logic        reset, start, in_valid, in_ready;
  logic [47:0] in_pair;
  logic        horizontal_Pulse, busy, frame_done;
  logic [7:0]  re, ge, be, ro, go, bo;
  logic [1:0]  row, col;

  // Instance with BLANK_CYCLES = 0
  logic        start0, in_valid0, in_ready0;
  logic [47:0] in_pair0;
  logic        pulse0, busy0, frame_done0;
  logic [7:0]  re0, ge0, be0, ro0, go0, bo0;
  logic [1:0]  row0, col0;

  frame_write_scheduler #(
    .IMAGE_WIDTH (W), .IMAGE_HEIGHT (H), .BLANK_CYCLES (2), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .in_valid (in_valid), .in_ready (in_ready), .in_pair (in_pair),
    .horizontal_Pulse (horizontal_Pulse),
    .data_Red_Even (re), .data_Green_Even (ge), .data_Blue_Even (be),
    .data_Red_Odd (ro), .data_Green_Odd (go), .data_Blue_Odd (bo),
    .row (row), .col (col), .busy (busy), .frame_done (frame_done)
  );

  frame_write_scheduler #(
    .IMAGE_WIDTH (W), .IMAGE_HEIGHT (H), .BLANK_CYCLES (0), .FIFO_DEPTH (4)
  ) dut0 (
    .clk (clk), .reset (reset), .start (start0),
    .in_valid (in_valid0), .in_ready (in_ready0), .in_pair (in_pair0),
    .horizontal_Pulse (pulse0),
    .data_Red_Even (re0), .data_Green_Even (ge0), .data_Blue_Even (be0),
    .data_Red_Odd (ro0), .data_Green_Odd (go0), .data_Blue_Odd (bo0),
    .row (row0), .col (col0), .busy (busy0), .frame_done (frame_done0)
  );

  // Pair k carries byte k in every channel, offset per channel.
  function automatic logic [47:0] make_pair(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, b + 8'h20, b + 8'h40, b + 8'h60, b + 8'h80, b + 8'hA0};
  endfunction

  // Upstream source: presents pair push_cnt until NPAIR pairs are accepted.
  logic valid_en = 1'b0, sparse = 1'b0, clr_idx = 1'b0, valid_en0 = 1'b0;
  int   push_cnt = 0, push_cnt0 = 0;

  assign in_valid  = valid_en && (push_cnt < NPAIR) && (!sparse || (cyc % 3 == 0));
  assign in_pair   = make_pair(push_cnt);
  assign in_valid0 = valid_en0 && (push_cnt0 < NPAIR);
  assign in_pair0  = make_pair(push_cnt0);

  always @(posedge clk) begin
    if (clr_idx)                    push_cnt <= 0;
    else if (in_valid && in_ready)  push_cnt <= push_cnt + 1;
    if (in_valid0 && in_ready0)     push_cnt0 <= push_cnt0 + 1;
  end

  // Observation logs, sampled on the falling edge.
  pulse_t plog[$];
  pulse_t plog0[$];
  int     push_log[$];
  int     fd_log[$];
  logic   rdy_hist [4096];

  always @(negedge clk) begin
    pulse_t p;
    if (horizontal_Pulse) begin
      p.cyc = cyc; p.row = row; p.col = col; p.data = {re, ge, be, ro, go, bo};
      plog.push_back(p);
    end
    if (pulse0) begin
      p.cyc = cyc; p.row = row0; p.col = col0; p.data = {re0, ge0, be0, ro0, go0, bo0};
      plog0.push_back(p);
    end
    if (in_valid && in_ready) push_log.push_back(cyc);
    if (frame_done)           fd_log.push_back(cyc);
    if (cyc < 4096)           rdy_hist[cyc] = in_ready;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) on falling edges for frame_done of the gapped instance.
  task automatic wait_done(input string tag, output int fcyc);
    int n;
    n = 0;
    while (!frame_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, frame_done, 1'b1);
    fcyc = cyc;
  endtask

  // Scoreboard over one frame: pair k must appear at (k/4, k%4) in order,
  // either at its exact cycle or no earlier than two cycles after its push.
  task automatic check_frame(input string tag, input bit sel, input int pbase,
                             input int ubase, input int t0, input bit exact,
                             input int fcyc);
    int     n, step, last;
    pulse_t p;
    n    = sel ? plog0.size() - pbase : plog.size() - pbase;
    step = sel ? 4 : 6;
    check({tag, "_count"}, n, NPAIR);
    last = 0;
    for (int k = 0; k < NPAIR && k < n; k++) begin
      p = sel ? plog0[pbase + k] : plog[pbase + k];
      last = p.cyc;
      check({tag, "_pair"}, {p.row, p.col, p.data}, {2'(k / 4), 2'(k % 4), make_pair(k)});
      if (exact)
        check({tag, "_cyc"}, p.cyc - t0, 3 + step * (k / 4) + (k % 4));
      else if (ubase + k < push_log.size())
        check({tag, "_after_push"}, p.cyc >= push_log[ubase + k] + 2, 1'b1);
    end
    check({tag, "_done_lag"}, fcyc - last, 1);
  endtask

  initial begin
    int t0, fcyc, pbase, ubase, fd_before, n;

    reset = 1'b1; start = 1'b0; start0 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pulse", horizontal_Pulse, 1'b0);
    check("rst_data",  {re, ge, be, ro, go, bo}, 48'h0);
    check("rst_pos",   {row, col}, 4'h0);
    check("rst_flags", {busy, frame_done, in_ready}, 3'b000);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", in_ready, 1'b0);

    // Frame 1: source always valid; start pulsed in ACTIVE and BLANK.
    valid_en = 1'b1;
    pbase = plog.size(); ubase = push_log.size();
    start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;                       // t0+4, ACTIVE
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;       // t0+7, BLANK
    check("f1_gap_a", horizontal_Pulse, 1'b0);
    @(negedge clk); start = 1'b0;
    check("f1_gap_b", horizontal_Pulse, 1'b0);
    wait_done("f1", fcyc);
    check("f1_done_cyc", fcyc - t0, 25);
    check("f1_busy_at_done", busy, 1'b1);
    check_frame("f1", 1'b0, pbase, ubase, t0, 1'b1, fcyc);
    check("f1_rdy_start",  rdy_hist[t0],      1'b0);
    check("f1_rdy_first",  rdy_hist[t0 + 1],  1'b1);
    check("f1_rdy_blank",  rdy_hist[t0 + 12], 1'b1);
    check("f1_rdy_full_a", rdy_hist[t0 + 13], 1'b0);
    check("f1_rdy_full_b", rdy_hist[t0 + 14], 1'b0);
    check("f1_rdy_resume", rdy_hist[t0 + 15], 1'b1);
    @(negedge clk);
    check("f1_after_done", {busy, frame_done, in_ready}, 3'b000);

    // Frame 2: restart one cycle after frame_done, source valid every third cycle.
    sparse = 1'b1; clr_idx = 1'b1;
    pbase = plog.size(); ubase = push_log.size();
    start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0; clr_idx = 1'b0;
    check("f2_busy", busy, 1'b1);
    wait_done("f2", fcyc);
    check_frame("f2", 1'b0, pbase, ubase, t0, 1'b0, fcyc);
    check("f2_pushes", push_log.size() - ubase, NPAIR);

    // Frame 3: reset while pair (2,1) is presented.
    @(negedge clk);
    sparse = 1'b0; clr_idx = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; clr_idx = 1'b0;
    n = 0;
    while (!(horizontal_Pulse && row == 2'd2 && col == 2'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("f3_at_2_1", {horizontal_Pulse, row, col}, {1'b1, 2'd2, 2'd1});
    fd_before = fd_log.size();
    reset = 1'b1; valid_en = 1'b0; clr_idx = 1'b1;
    @(negedge clk);
    check("f3_rst_pulse", horizontal_Pulse, 1'b0);
    check("f3_rst_data",  {re, ge, be, ro, go, bo}, 48'h0);
    check("f3_rst_pos",   {row, col}, 4'h0);
    check("f3_rst_flags", {busy, frame_done, in_ready}, 3'b000);
    reset = 1'b0; clr_idx = 1'b0;
    repeat (6) @(negedge clk);
    check("f3_no_done", fd_log.size() - fd_before, 0);

    // Frame 4: clean frame after the aborted one.
    valid_en = 1'b1;
    pbase = plog.size(); ubase = push_log.size();
    start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    wait_done("f4", fcyc);
    check_frame("f4", 1'b0, pbase, ubase, t0, 1'b1, fcyc);

    // Frame 5: no row gap on the second instance.
    @(negedge clk);
    valid_en0 = 1'b1;
    pbase = plog0.size();
    start0 = 1'b1; t0 = cyc;
    @(negedge clk); start0 = 1'b0;
    n = 0;
    while (!frame_done0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("f5_done_seen", frame_done0, 1'b1);
    fcyc = cyc;
    check("f5_done_cyc", fcyc - t0, 19);
    check_frame("f5", 1'b1, pbase, 0, t0, 1'b1, fcyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
